// File: rtl/thresh_pwm_ctrl_if.sv
// Threshold write port and PWM/status outputs of thresh_pwm_ctrl.
// Master drives writes (host side); slave is the controller.
interface thresh_pwm_ctrl_if;
   logic       wrt;
   logic       sel;
   logic [7:0] data;
   logic       VIL_PWM;
   logic       VIH_PWM;
   logic [7:0] VIL;
   logic [7:0] VIH;
   logic       rdy;
   logic       err;

   modport master (
      output wrt, sel, data,
      input  VIL_PWM, VIH_PWM, VIL, VIH, rdy, err
   );

   modport slave (
      input  wrt, sel, data,
      output VIL_PWM, VIH_PWM, VIL, VIH, rdy, err
   );
endinterface

// File: rtl/thresh_pwm_ctrl.sv
// Dual-threshold PWM generator for an analog front end: shadow/active threshold pairs,
// loads aligned to the 1024-clock PWM period, and a settle window before new writes are taken.
module thresh_pwm_ctrl #(
   parameter int unsigned SETTLE_PERIODS = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   thresh_pwm_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      SETTLE = 2'd0,
      IDLE   = 2'd1,
      PEND   = 2'd2
   } state_t;

   localparam logic [2:0] SETTLE_CNT = 3'(SETTLE_PERIODS);
   localparam logic [7:0] VIL_RST    = 8'h55;
   localparam logic [7:0] VIH_RST    = 8'hAA;

   state_t     r_state;
   state_t     w_next_state;
   logic [9:0] r_cnt;
   logic [2:0] r_per_cnt;
   logic [2:0] w_next_per_cnt;
   logic [7:0] r_sh_vil;
   logic [7:0] r_sh_vih;
   logic [7:0] r_act_vil;
   logic [7:0] r_act_vih;
   logic       r_vil_pwm;
   logic       r_vih_pwm;
   logic       r_err;
   logic       r_rdy;
   logic       w_wrap;
   logic       w_valid;
   logic       w_accept;
   logic       w_load;

   assign w_wrap   = (r_cnt == 10'd1023);
   // Ordering is checked against the other channel's shadow so pending pairs stay consistent.
   assign w_valid  = bus.sel ? (bus.data > r_sh_vil) : (bus.data < r_sh_vih);
   assign w_accept = bus.wrt && (r_state == IDLE) && w_valid;
   assign w_load   = (r_state == PEND) && w_wrap;

   // Next-state and settle-period counting
   always_comb begin
      w_next_state   = r_state;
      w_next_per_cnt = r_per_cnt;
      case (r_state)
         SETTLE: begin
            if (w_wrap) begin
               w_next_per_cnt = r_per_cnt + 3'd1;
               if (w_next_per_cnt == SETTLE_CNT) begin
                  w_next_state = IDLE;
               end else begin
                  w_next_state = SETTLE;
               end
            end else begin
               w_next_state = SETTLE;
            end
         end
         IDLE: begin
            if (w_accept) begin
               w_next_state = PEND;
            end else begin
               w_next_state = IDLE;
            end
         end
         PEND: begin
            if (w_wrap) begin
               w_next_state   = SETTLE;
               w_next_per_cnt = 3'd0;
            end else begin
               w_next_state = PEND;
            end
         end
         default: begin
            w_next_state   = SETTLE;
            w_next_per_cnt = 3'd0;
         end
      endcase
   end

   // State, period counter and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= SETTLE;
         r_cnt     <= 10'd0;
         r_per_cnt <= 3'd0;
         r_err     <= 1'b0;
         r_rdy     <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_cnt     <= r_cnt + 10'd1;
         r_per_cnt <= w_next_per_cnt;
         r_err     <= bus.wrt && !w_accept;
         r_rdy     <= (w_next_state == IDLE);
      end
   end

   // Shadow capture on accepted writes, active load at period boundary
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_vil  <= VIL_RST;
         r_sh_vih  <= VIH_RST;
         r_act_vil <= VIL_RST;
         r_act_vih <= VIH_RST;
      end else begin
         if (w_accept && !bus.sel) begin
            r_sh_vil <= bus.data;
         end
         if (w_accept && bus.sel) begin
            r_sh_vih <= bus.data;
         end
         if (w_load) begin
            r_act_vil <= r_sh_vil;
            r_act_vih <= r_sh_vih;
         end
      end
   end

   // High-time is 4 clocks per threshold LSB; 0xFF tops out at 1020 so the period never saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vil_pwm <= 1'b0;
         r_vih_pwm <= 1'b0;
      end else begin
         r_vil_pwm <= (r_cnt < {r_act_vil, 2'b00});
         r_vih_pwm <= (r_cnt < {r_act_vih, 2'b00});
      end
   end

   assign bus.VIL_PWM = r_vil_pwm;
   assign bus.VIH_PWM = r_vih_pwm;
   assign bus.VIL     = r_act_vil;
   assign bus.VIH     = r_act_vih;
   assign bus.rdy     = r_rdy;
   assign bus.err     = r_err;

endmodule

// File: tb/tb_thresh_pwm_ctrl.sv
// Bench for thresh_pwm_ctrl: a transaction-level model checked every cycle, directed
// scenarios pinned with hand-computed values, then randomized writes.
module tb_thresh_pwm_ctrl;
   localparam int SP = 2;

   logic clk;
   logic rst_n;
   thresh_pwm_ctrl_if bus ();

   thresh_pwm_ctrl #(.SETTLE_PERIODS(SP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [10:0] cnt;
      logic [7:0]  sh_l;
      logic [7:0]  sh_h;
      logic [7:0]  act_l;
      logic [7:0]  act_h;
      logic        pending;
      logic [3:0]  settle_left;
      logic        err;
      logic        pwm_l;
      logic        pwm_h;
   } model_t;

   model_t m;
   int     n_checks = 0;
   int     n_errors = 0;
   int     cyc = 0;

   function automatic model_t model_reset();
      model_t r;
      r.cnt = 11'd0;  r.sh_l = 8'h55;  r.sh_h = 8'hAA;  r.act_l = 8'h55;  r.act_h = 8'hAA;
      r.pending = 1'b0;  r.settle_left = 4'(SP);  r.err = 1'b0;  r.pwm_l = 1'b0;  r.pwm_h = 1'b0;
      return r;
   endfunction

   function automatic logic model_rdy(model_t s);
      return !s.pending && (s.settle_left == 4'd0);
   endfunction

   // One clock of the controller described in terms of pending load and settle periods left
   function automatic model_t model_step(model_t s, logic wrt, logic sel, logic [7:0] data);
      model_t n = s;
      logic valid = sel ? (data > s.sh_l) : (data < s.sh_h);
      logic accept = wrt && model_rdy(s) && valid;
      n.err   = wrt && !accept;
      n.pwm_l = (int'(s.cnt) < 4 * int'(s.act_l));
      n.pwm_h = (int'(s.cnt) < 4 * int'(s.act_h));
      if (s.cnt == 11'd1023) begin
         if (s.pending) begin
            n.act_l = s.sh_l;  n.act_h = s.sh_h;
            n.pending = 1'b0;  n.settle_left = 4'(SP);
         end else if (s.settle_left != 4'd0) begin
            n.settle_left = s.settle_left - 4'd1;
         end
      end
      if (accept) begin
         if (sel) n.sh_h = data;
         else     n.sh_l = data;
         n.pending = 1'b1;
      end
      n.cnt = (s.cnt + 11'd1) % 11'd1024;
      return n;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= model_reset();
      else        m <= model_step(m, bus.wrt, bus.sel, bus.data);
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model
   always @(negedge clk) begin
      if (rst_n) begin
         chk("VIL",     int'(bus.VIL),     int'(m.act_l));
         chk("VIH",     int'(bus.VIH),     int'(m.act_h));
         chk("VIL_PWM", int'(bus.VIL_PWM), int'(m.pwm_l));
         chk("VIH_PWM", int'(bus.VIH_PWM), int'(m.pwm_h));
         chk("rdy",     int'(bus.rdy),     int'(model_rdy(m)));
         chk("err",     int'(bus.err),     int'(m.err));
      end
   end

   task automatic wait_cnt(input int v);
      int n = 0;
      @(negedge clk);
      while (int'(m.cnt) != v && n < 1100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1100) chk("wait_cnt_timeout", 0, 1);
   endtask

   task automatic wait_rdy();
      int n = 0;
      while (!bus.rdy && n < 4000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 4000) chk("wait_rdy_timeout", 0, 1);
   endtask

   // Sums high cycles and rising edges over one period aligned to k = 0..1023
   task automatic measure(output int hl, output int hh, output int rl);
      logic prev;
      hl = 0;  hh = 0;  rl = 0;
      wait_cnt(1);
      prev = bus.VIL_PWM;
      for (int i = 0; i < 1024; i++) begin
         hl += int'(bus.VIL_PWM);
         hh += int'(bus.VIH_PWM);
         if (bus.VIL_PWM && !prev) rl++;
         prev = bus.VIL_PWM;
         @(negedge clk);
      end
   endtask

   task automatic write(input logic sel, input logic [7:0] data);
      bus.wrt = 1'b1;  bus.sel = sel;  bus.data = data;
      @(negedge clk);
      bus.wrt = 1'b0;
   endtask

   int hl, hh, rl;

   initial begin
      rst_n = 1'b0;  bus.wrt = 1'b0;  bus.sel = 1'b0;  bus.data = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_VIL", int'(bus.VIL), 8'h55);
      chk("rst_VIH", int'(bus.VIH), 8'hAA);
      chk("rst_rdy", int'(bus.rdy), 0);
      chk("rst_pwm", int'({bus.VIL_PWM, bus.VIH_PWM}), 0);
      rst_n = 1'b1;

      // Default thresholds and settle after reset
      measure(hl, hh, rl);
      chk("default_vil_high", hl, 340);
      chk("default_vih_high", hh, 680);
      wait_rdy();
      chk("rdy_rise_cycle", cyc, 2048);

      // Out-of-order VIH rejected
      @(negedge clk);
      write(1'b1, 8'h40);
      chk("rej_err", int'(bus.err), 1);
      chk("rej_VIH", int'(bus.VIH), 8'hAA);
      chk("rej_rdy", int'(bus.rdy), 1);

      // VIL=0x20 accepted at cnt=100
      wait_cnt(100);
      write(1'b0, 8'h20);
      chk("acc_rdy_low", int'(bus.rdy), 0);
      chk("acc_VIL_held", int'(bus.VIL), 8'h55);
      measure(hl, hh, rl);
      chk("vil20_high", hl, 128);
      chk("vil20_VIL", int'(bus.VIL), 8'h20);

      // Asynchronous reset mid-SETTLE
      #2 rst_n = 1'b0;
      #1;
      chk("arst_VIL", int'(bus.VIL), 8'h55);
      chk("arst_vil_pwm", int'(bus.VIL_PWM), 0);
      chk("arst_vih_pwm", int'(bus.VIH_PWM), 0);
      chk("arst_rdy", int'(bus.rdy), 0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_rdy();

      // Extremes: 0x00 never rises, 0xFF is low for 4 clocks
      @(negedge clk);
      write(1'b0, 8'h00);
      measure(hl, hh, rl);
      chk("zero_high", hl, 0);
      chk("zero_rises", rl, 0);
      wait_rdy();
      @(negedge clk);
      write(1'b1, 8'hFF);
      measure(hl, hh, rl);
      chk("ff_high", hh, 1020);
      wait_rdy();

      // Write on the wrap edge waits a full period; a second write while pending is rejected
      wait_cnt(1023);
      write(1'b0, 8'h10);
      repeat (3) @(negedge clk);
      write(1'b1, 8'h80);
      chk("pend_err", int'(bus.err), 1);
      wait_cnt(1000);
      chk("pend_VIL_held", int'(bus.VIL), 8'h00);
      measure(hl, hh, rl);
      chk("late_load_high", hl, 64);
      chk("late_load_VIH", int'(bus.VIH), 8'hFF);
      wait_rdy();

      // Randomized writes with one asynchronous reset in the middle
      for (int i = 0; i < 24000; i++) begin
         @(negedge clk);
         if (i == 12000) begin
            #3 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
         end else if ($urandom_range(0, 249) == 0) begin
            write(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
         end
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/thresh_pwm_ctrl.md
THRESH_PWM_CTRL -- requirements
Module: thresh_pwm_ctrl

Interface
REQ-001 Parameter: SETTLE_PERIODS, default 2, number of complete PWM periods with new duty before rdy reasserts (legal 1..7).
REQ-002 clk  input  1  system clock, same clock that drives smpl_clk of the analog front end.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wrt  input  1  single-cycle threshold write strobe.
REQ-005 sel  input  1  write target: 0 = VIL, 1 = VIH.
REQ-006 data  input  8  threshold value to write.
REQ-007 VIL_PWM  output  1  PWM whose duty encodes VIL, registered.
REQ-008 VIH_PWM  output  1  PWM whose duty encodes VIH, registered.
REQ-009 VIL  output  8  threshold currently being driven on VIL_PWM (active register).
REQ-010 VIH  output  8  threshold currently being driven on VIH_PWM (active register).
REQ-011 rdy  output  1  high when a new write is accepted and the front end has settled.
REQ-012 err  output  1  one-cycle pulse on a rejected write.

Function
REQ-013 10-bit period counter cnt SHALL increment every clk, wrapping 1023->0; PWM period is exactly 1024 clocks.
REQ-014 Each channel SHALL hold an 8-bit shadow register (written by wrt) and an 8-bit active register (drives PWM).
REQ-015 Active registers SHALL load from shadow registers only on the clk edge where cnt==1023, only in state PEND; the value in the shadow before that edge is loaded.
REQ-016 VIL_PWM in the cycle after cnt==k SHALL equal (k < 4*VIL); VIH_PWM likewise with VIH; one-cycle registered latency, high-time = 4*threshold clocks per period.
REQ-017 Threshold 0x00 SHALL yield a PWM constantly low for the whole period (no rising edge); 0xFF SHALL yield 1020 high, 4 low.
REQ-018 States: SETTLE, IDLE, PEND; rdy SHALL be 1 only in IDLE.
REQ-019 IDLE: wrt with valid data SHALL update the selected shadow register and move to PEND; rdy SHALL be 0 the following cycle.
REQ-020 Valid write: sel=0 requires data < VIH shadow; sel=1 requires data > VIL shadow (unsigned 8-bit compare).
REQ-021 Invalid write in IDLE SHALL leave all registers and state unchanged and pulse err for exactly one cycle.
REQ-022 wrt while in PEND or SETTLE SHALL be ignored for registers/state and SHALL pulse err for one cycle.
REQ-023 PEND: on cnt==1023 edge load active registers, clear 3-bit period counter per_cnt, move to SETTLE.
REQ-024 SETTLE: on each cnt==1023 edge increment per_cnt; when incremented value equals SETTLE_PERIODS move to IDLE (rdy=1 next cycle).
REQ-025 A valid write accepted on the cnt==1023 edge SHALL NOT be loaded that edge; it SHALL wait for the next cnt==1023 edge (full period in PEND).
REQ-026 err and rdy SHALL never be 1 in the same cycle as a state change caused by the same wrt.

Reset
REQ-027 On rst_n low, asynchronously: cnt=0, per_cnt=0, shadow and active VIL=0x55, VIH=0xAA, VIL_PWM=0, VIH_PWM=0, err=0, rdy=0, state=SETTLE.
REQ-028 After rst_n release, rdy SHALL assert after SETTLE_PERIODS complete periods, matching the front end's default 0x55/0xAA thresholds.
REQ-029 rst_n asserted mid-operation (any state) SHALL discard pending shadow values and apply REQ-027 without waiting for a clock.

Verification
REQ-030 Reset release, no writes -> VIL_PWM high 340 clocks, VIH_PWM high 680 clocks per 1024-clock period; rdy rises one cycle after second cnt==1023 edge (SETTLE_PERIODS=2).
REQ-031 IDLE, wrt sel=0 data=0x20 at cnt=100 -> rdy=0 next cycle; VIL stays 0x55 until cnt==1023 edge, then 0x20; VIL_PWM high 128 clocks; rdy=1 after two further periods.
REQ-032 IDLE, VIL=0x55, wrt sel=1 data=0x40 -> err pulses one cycle, VIH stays 0xAA, rdy stays 1.
REQ-033 IDLE, wrt sel=0 data=0x00 -> after load, VIL_PWM has no rising edge for a full period; wrt sel=1 data=0xFF -> VIH_PWM high 1020, low 4.
REQ-034 wrt at cnt==1023 and a second wrt during PEND -> first loaded one period later, second produces err pulse and no register change.
REQ-035 rst_n low mid-SETTLE after VIL=0x20 load -> VIL=0x55, both PWMs 0, rdy=0 immediately, before next clk edge.
